// File: rtl/fifo_sync_flags_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// Read-mode selection and count-width sizing live here so every user agrees on them.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_mem.sv
// Flop-array storage for the FIFO: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; pointer state alone defines what is valid.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Wr_En,
  input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  input  logic [ADDR_WIDTH-1:0] i_Rd_Addr,
  output logic [DATA_WIDTH-1:0] o_Rd_Data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_Mem [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_Wr_En) begin
      r_Mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = r_Mem[i_Rd_Addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags and error pulses.
// Read mode is fixed at build time: registered read (standard) or first-word-fall-through.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  input  logic                  i_Wr_En,
  input  logic                  i_Rd_En,
  output logic [DATA_WIDTH-1:0] o_Rd_Data,
  output logic                  o_Data_Valid,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam int         CW    = count_width(DEPTH);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_Wr_Ptr;
  logic [ADDR_WIDTH-1:0] r_Rd_Ptr;
  logic [CW-1:0]         r_Count;
  logic                  r_Overflow;
  logic                  r_Underflow;

  logic                  w_Full;
  logic                  w_Empty;
  logic                  w_Wr_Ok;
  logic                  w_Rd_Ok;
  logic [DATA_WIDTH-1:0] w_Mem_Rd_Data;

  assign w_Full  = (r_Count == FULL_CNT);
  assign w_Empty = (r_Count == '0);

  // Acceptance looks only at registered state, so a same-cycle read never frees room for a write.
  assign w_Wr_Ok = i_Wr_En & ~w_Full;
  assign w_Rd_Ok = i_Rd_En & ~w_Empty;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Wr_Ptr    <= '0;
      r_Rd_Ptr    <= '0;
      r_Count     <= '0;
      r_Overflow  <= 1'b0;
      r_Underflow <= 1'b0;
    end else begin
      if (w_Wr_Ok) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_Rd_Ok) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
      case ({w_Wr_Ok, w_Rd_Ok})
        2'b10:   r_Count <= r_Count + CW'(1);
        2'b01:   r_Count <= r_Count - CW'(1);
        default: r_Count <= r_Count;
      endcase
      r_Overflow  <= i_Wr_En & w_Full;
      r_Underflow <= i_Rd_En & w_Empty;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_Clk     (i_Clk),
    .i_Wr_En   (w_Wr_Ok),
    .i_Wr_Addr (r_Wr_Ptr),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_Addr (r_Rd_Ptr),
    .o_Rd_Data (w_Mem_Rd_Data)
  );

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] r_Rd_Data;
      logic                  r_Data_Valid;

      // Output word holds its last value between reads; only the valid strobe drops.
      always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
          r_Rd_Data    <= '0;
          r_Data_Valid <= 1'b0;
        end else begin
          r_Data_Valid <= w_Rd_Ok;
          if (w_Rd_Ok) begin
            r_Rd_Data <= w_Mem_Rd_Data;
          end
        end
      end

      assign o_Rd_Data    = r_Rd_Data;
      assign o_Data_Valid = r_Data_Valid;
    end else begin : g_fwft
      assign o_Rd_Data    = w_Mem_Rd_Data;
      assign o_Data_Valid = ~w_Empty;
    end
  endgenerate

  assign o_Full         = w_Full;
  assign o_Empty        = w_Empty;
  assign o_Almost_Full  = (r_Count >= AF_CNT);
  assign o_Almost_Empty = (r_Count <= AE_CNT);
  assign o_Count        = r_Count;
  assign o_Overflow     = r_Overflow;
  assign o_Underflow    = r_Underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO (depth 4) against a queue model.
// Expected read words are queued when a read is accepted by the model and popped as the DUT presents them.
module tb_fifo_sync_flags;

  logic       clk;
  logic       rstN;

  logic [7:0] stdWrData;
  logic       stdWrEn;
  logic       stdRdEn;
  logic [7:0] stdRdData;
  logic       stdValid, stdFull, stdEmpty, stdAf, stdAe, stdOvf, stdUnf;
  logic [2:0] stdCount;

  logic [7:0] fwWrData;
  logic       fwWrEn;
  logic       fwRdEn;
  logic [7:0] fwRdData;
  logic       fwValid, fwFull, fwEmpty, fwAf, fwAe, fwOvf, fwUnf;
  logic [2:0] fwCount;

  int checks = 0;
  int errors = 0;

  int         mCount = 0;
  logic [7:0] modelQ[$];
  logic [7:0] expQ[$];
  logic       expValid, expOvf, expUnf;

  fifo_sync_flags #(
    .DATA_WIDTH (8), .ADDR_WIDTH (2), .AF_THRESH (3), .AE_THRESH (1), .FWFT (0)
  ) u_std (
    .i_Clk          (clk),
    .i_Reset_n      (rstN),
    .i_Wr_Data      (stdWrData),
    .i_Wr_En        (stdWrEn),
    .i_Rd_En        (stdRdEn),
    .o_Rd_Data      (stdRdData),
    .o_Data_Valid   (stdValid),
    .o_Full         (stdFull),
    .o_Empty        (stdEmpty),
    .o_Almost_Full  (stdAf),
    .o_Almost_Empty (stdAe),
    .o_Count        (stdCount),
    .o_Overflow     (stdOvf),
    .o_Underflow    (stdUnf)
  );

  fifo_sync_flags #(
    .DATA_WIDTH (8), .ADDR_WIDTH (2), .AF_THRESH (3), .AE_THRESH (1), .FWFT (1)
  ) u_fwft (
    .i_Clk          (clk),
    .i_Reset_n      (rstN),
    .i_Wr_Data      (fwWrData),
    .i_Wr_En        (fwWrEn),
    .i_Rd_En        (fwRdEn),
    .o_Rd_Data      (fwRdData),
    .o_Data_Valid   (fwValid),
    .o_Full         (fwFull),
    .o_Empty        (fwEmpty),
    .o_Almost_Full  (fwAf),
    .o_Almost_Empty (fwAe),
    .o_Count        (fwCount),
    .o_Overflow     (fwOvf),
    .o_Underflow    (fwUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One standard-mode cycle: drive, advance the model, then sample 1 time unit after the edge.
  task automatic stdCycle(input logic wr, input logic [7:0] d, input logic rd);
    logic wrOk, rdOk;
    stdWrEn   = wr;
    stdWrData = d;
    stdRdEn   = rd;
    wrOk     = wr && (mCount < 4);
    rdOk     = rd && (mCount > 0);
    expOvf   = wr && (mCount == 4);
    expUnf   = rd && (mCount == 0);
    expValid = rdOk;
    if (rdOk) expQ.push_back(modelQ.pop_front());
    if (wrOk) modelQ.push_back(d);
    mCount = mCount + int'(wrOk) - int'(rdOk);
    @(posedge clk);
    #1;
    stdWrEn = 1'b0;
    stdRdEn = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stdCount, stdEmpty, stdAe, stdFull, stdAf} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_flags: got count=%0d e=%b ae=%b f=%b af=%b, want count=0 e=1 ae=1 f=0 af=0",
               stdCount, stdEmpty, stdAe, stdFull, stdAf);
    end
    checks++;
    if ({stdValid, stdRdData, stdOvf, stdUnf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_out: got v=%b data=%h ovf=%b unf=%b, want 0 00 0 0",
               stdValid, stdRdData, stdOvf, stdUnf);
    end
    rstN = 1'b1;
    #2;
    stdCycle(1'b1, 8'hA1, 1'b0);
    checks++;
    if ({stdCount, stdEmpty, stdAe} !== {3'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL first_write: got count=%0d e=%b ae=%b, want 1 0 1", stdCount, stdEmpty, stdAe);
    end
    stdCycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (stdValid) begin
      if (expQ.size() == 0 || stdRdData !== expQ[0] || stdRdData !== 8'hA1) begin
        errors++;
        $display("[TB] FAIL first_read: got %h, want a1", stdRdData);
      end
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      errors++;
      $display("[TB] FAIL first_read_valid: got 0, want 1");
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      stdCycle(1'b1, 8'h10 + 8'(i), 1'b0);
      checks++;
      if (stdCount !== 3'(i + 1) || stdAf !== (i + 1 >= 3) || stdFull !== (i + 1 == 4) || stdAe !== (i + 1 <= 1)) begin
        errors++;
        $display("[TB] FAIL fill_%0d: got count=%0d af=%b f=%b ae=%b, want count=%0d af=%b f=%b ae=%b",
                 i, stdCount, stdAf, stdFull, stdAe, i + 1, (i + 1 >= 3), (i + 1 == 4), (i + 1 <= 1));
      end
    end
    stdCycle(1'b1, 8'h14, 1'b0);
    checks++;
    if (stdOvf !== 1'b1 || stdCount !== 3'd4 || stdOvf !== expOvf) begin
      errors++;
      $display("[TB] FAIL overflow: got ovf=%b count=%0d, want ovf=1 count=4", stdOvf, stdCount);
    end
    stdCycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (stdOvf !== 1'b0 || stdFull !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_pulse: got ovf=%b full=%b, want ovf=0 full=1", stdOvf, stdFull);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      stdCycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (stdValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_valid_%0d: got %b, want 1", i, stdValid);
      end else begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        if (stdRdData !== exp || stdRdData !== 8'h10 + 8'(i)) begin
          errors++;
          $display("[TB] FAIL drain_data_%0d: got %h, want %h", i, stdRdData, 8'h10 + 8'(i));
        end
      end
    end
    stdCycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (stdUnf !== 1'b1 || stdValid !== 1'b0 || stdCount !== 3'd0 || stdUnf !== expUnf) begin
      errors++;
      $display("[TB] FAIL underflow: got unf=%b v=%b count=%0d, want unf=1 v=0 count=0", stdUnf, stdValid, stdCount);
    end
    stdCycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (stdUnf !== 1'b0 || stdEmpty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow_pulse: got unf=%b empty=%b, want 0 1", stdUnf, stdEmpty);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    // Each row: write, data, read, expected count, expected ovf, expected unf.
    logic [7:0] tblD   [16] = '{8'h20, 8'h21, 8'h22, 8'h00, 8'h00, 8'h30, 8'h00,
                               8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       tblWr  [16] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic       tblRd  [16] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int         tblCnt [16] = '{1, 2, 2, 1, 0, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0};
    logic       tblOvf [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic       tblUnf [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      stdCycle(tblWr[i], tblD[i], tblRd[i]);
      checks++;
      if (stdCount !== 3'(tblCnt[i]) || stdOvf !== tblOvf[i] || stdUnf !== tblUnf[i] || stdValid !== expValid) begin
        errors++;
        $display("[TB] FAIL simul_%0d: got count=%0d ovf=%b unf=%b v=%b, want count=%0d ovf=%b unf=%b v=%b",
                 i, stdCount, stdOvf, stdUnf, stdValid, tblCnt[i], tblOvf[i], tblUnf[i], expValid);
      end
      if (stdValid) begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        checks++;
        if (stdRdData !== exp) begin
          errors++;
          $display("[TB] FAIL simul_data_%0d: got %h, want %h", i, stdRdData, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 10; i++) begin
      stdCycle(1'b1, 8'(i), 1'b0);
      stdCycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (stdValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wrap_valid_%0d: got %b, want 1", i, stdValid);
      end else begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        if (stdRdData !== exp || stdRdData !== 8'(i)) begin
          errors++;
          $display("[TB] FAIL wrap_data_%0d: got %h, want %h", i, stdRdData, 8'(i));
        end
      end
    end
    // Sustained throughput: one write and one read in every cycle with the FIFO part-full.
    stdCycle(1'b1, 8'h70, 1'b0);
    for (int i = 1; i < 8; i++) begin
      stdCycle(1'b1, 8'h70 + 8'(i), 1'b1);
      checks++;
      if (stdValid !== 1'b1 || stdCount !== 3'd1) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got v=%b count=%0d, want v=1 count=1", i, stdValid, stdCount);
      end else begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        if (stdRdData !== exp || stdRdData !== 8'h70 + 8'(i - 1)) begin
          errors++;
          $display("[TB] FAIL b2b_data_%0d: got %h, want %h", i, stdRdData, 8'h70 + 8'(i - 1));
        end
      end
    end
    stdCycle(1'b0, 8'h00, 1'b1);
    if (stdValid && expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic test_fwft();
    fwWrData = 8'h5A;
    fwWrEn   = 1'b1;
    @(posedge clk);
    #1;
    fwWrEn = 1'b0;
    checks++;
    if (fwRdData !== 8'h5A || fwValid !== 1'b1 || fwEmpty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwft_show: got data=%h v=%b e=%b, want 5a 1 0", fwRdData, fwValid, fwEmpty);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwRdData !== 8'h5A || fwValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fwft_hold: got data=%h v=%b, want 5a 1", fwRdData, fwValid);
    end
    fwRdEn = 1'b1;
    @(posedge clk);
    #1;
    fwRdEn = 1'b0;
    checks++;
    if (fwValid !== 1'b0 || fwEmpty !== 1'b1 || fwCount !== 3'd0) begin
      errors++;
      $display("[TB] FAIL fwft_pop: got v=%b e=%b count=%0d, want 0 1 0", fwValid, fwEmpty, fwCount);
    end
    for (int i = 0; i < 3; i++) begin
      fwWrData = 8'h61 + 8'(i);
      fwWrEn   = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (fwRdData !== 8'h61 || fwCount !== 3'(i + 1)) begin
        errors++;
        $display("[TB] FAIL fwft_burst_%0d: got data=%h count=%0d, want 61 %0d", i, fwRdData, fwCount, i + 1);
      end
    end
    // Reset lands mid-cycle with a write still requested.
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({fwCount, fwEmpty, fwAe, fwFull, fwAf, fwValid, fwOvf, fwUnf} !==
        {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fwft_reset: got count=%0d e=%b ae=%b f=%b af=%b v=%b ovf=%b unf=%b, want 0 1 1 0 0 0 0 0",
               fwCount, fwEmpty, fwAe, fwFull, fwAf, fwValid, fwOvf, fwUnf);
    end
    fwWrEn = 1'b0;
    mCount = 0;
    modelQ.delete();
    expQ.delete();
    @(posedge clk);
    #1;
    checks++;
    if (fwCount !== 3'd0 || fwValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwft_reset_hold: got count=%0d v=%b, want 0 0", fwCount, fwValid);
    end
    rstN = 1'b1;
  endtask

  initial begin
    rstN      = 1'b0;
    stdWrEn   = 1'b0;
    stdRdEn   = 1'b0;
    stdWrData = 8'h00;
    fwWrEn    = 1'b0;
    fwRdEn    = 1'b0;
    fwWrData  = 8'h00;
    $display("[TB] starting fifo_sync_flags bench");
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_back_to_back();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised synchronous FIFO with a power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, and a build-time choice between standard (registered read) and first-word-fall-through (FWFT) read modes. It is the general-purpose single-clock buffer for datapath blocks that need back-pressure earlier than a hard full flag. Storage is a flop array. Pointer, count and flag logic sit in this block.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH (ADDR_WIDTH >= 1)
- AF_THRESH, DEPTH-1, o_Almost_Full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, o_Almost_Empty asserts when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through
- i_Clk  input  1  sole clock, rising edge
- i_Reset_n  input  1  asynchronous, active-low reset
- i_Wr_Data  input  DATA_WIDTH  write word
- i_Wr_En  input  1  write request
- i_Rd_En  input  1  read request (FWFT: pop/acknowledge)
- o_Rd_Data  output  DATA_WIDTH  read word
- o_Data_Valid  output  1  o_Rd_Data holds a valid word
- o_Full  output  1  count == DEPTH
- o_Empty  output  1  count == 0
- o_Almost_Full  output  1  count >= AF_THRESH
- o_Almost_Empty  output  1  count <= AE_THRESH
- o_Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- o_Overflow  output  1  one-cycle pulse: a write was rejected
- o_Underflow  output  1  one-cycle pulse: a read was rejected

## Operation
- Write acceptance: wr_ok = i_Wr_En & ~o_Full. Read acceptance: rd_ok = i_Rd_En & ~o_Empty. Both conditions use the registered state. A read in the same cycle does not free space for a write, and a write in the same cycle does not supply data for a read.
- On wr_ok, write mem[wr_ptr] and increment wr_ptr. On rd_ok, increment rd_ptr. Both pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. Count never leaves the range 0..DEPTH.
- Flags are decoded from the registered count and are therefore glitch-free. Thresholds are compared as unsigned values of ADDR_WIDTH+1 bits.
- o_Overflow is registered and equals i_Wr_En & o_Full from the previous cycle. o_Underflow likewise equals i_Rd_En & o_Empty from the previous cycle. Rejected operations change no state.
- Standard mode (FWFT=0): on rd_ok, o_Rd_Data <= mem[rd_ptr] and o_Data_Valid <= 1. Otherwise o_Data_Valid <= 0 and o_Rd_Data holds its last value.
- FWFT mode (FWFT=1): o_Rd_Data = mem[rd_ptr] combinationally and o_Data_Valid = ~o_Empty. i_Rd_En acknowledges the word currently shown.
- Reset, asynchronous and taking effect even mid-operation: pointers 0, count 0, o_Empty 1, o_Almost_Empty 1, o_Full 0, o_Almost_Full 0, o_Data_Valid 0, o_Rd_Data 0 (standard mode), o_Overflow 0, o_Underflow 0. Memory contents are not reset, so after reset the FIFO behaves as empty.

## Timing
- Write to visibility: a word written at edge N makes o_Empty fall after edge N. In FWFT mode that word is on o_Rd_Data in cycle N+1; in standard mode the earliest accepted read is at edge N+1 and its data is valid after that edge.
- Standard read latency: 1 cycle from rd_ok to o_Data_Valid.
- All flag and count updates are visible one cycle after the accepting edge.
- Back-to-back operation: one write and one read per cycle are sustained at full throughput whenever 0 < count < DEPTH.

## Structure
- Shared package fifo_pkg holds a read-mode enum (FIFO_STD, FIFO_FWFT) and a count-width helper function (clog2(DEPTH)+1). FWFT maps to this enum.
- One sub-module, fifo_mem: flop array with synchronous write (wr_en, wr_addr, wr_data) and asynchronous read (rd_addr, rd_data), parameterised by DATA_WIDTH and ADDR_WIDTH.
- This block keeps the pointers, count, flag decode, error pulses and the output register used in standard mode.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2, AF_THRESH=3, AE_THRESH=1.
- Reset release: all outputs at their reset values. Write 0xA1 -> next cycle o_Count=1, o_Empty=0, o_Almost_Empty=1.
- Fill: write 0x10, 0x11, 0x12, 0x13 on consecutive cycles -> o_Almost_Full rises when count reaches 3, o_Full=1 at count 4. A fifth write 0x14 -> o_Overflow pulses for one cycle, count stays 4.
- Standard-mode drain: from full, read 4 times -> o_Rd_Data = 0x10..0x13, each with o_Data_Valid one cycle after its read. A fifth read -> o_Underflow pulses, o_Data_Valid=0.
- Simultaneous events: at count 2, assert write and read together -> count stays 2 and data order is preserved. When empty, assert both -> only the write is accepted, o_Underflow pulses, count becomes 1. When full, assert both -> only the read is accepted, o_Overflow pulses, count becomes 3.
- Wrap-around: run 10 write/read pairs with data 0x00..0x09 -> output order matches input exactly and pointers pass through index 0 twice.
- FWFT=1: write 0x5A -> o_Rd_Data=0x5A with o_Data_Valid=1 in the next cycle, without asserting i_Rd_En. Assert i_Rd_En -> o_Data_Valid=0 in the next cycle. Assert i_Reset_n low mid-burst -> all flags return to reset values immediately.
